// File: rtl/dft_bin_acc_if.sv
// dft_bin_acc_if: complex sample stream in, per-frame single-bin DFT result out.
// The master side drives samples and clear; the slave (the correlator) returns
// the bin value, its one-cycle valid pulse and the completed-frame count.
interface dft_bin_acc_if #(
  parameter int N  = 64,
  parameter int SW = 16
);
  localparam int AW = SW + 17 + $clog2(N);

  logic                 clr_i;
  logic signed [SW-1:0] x_re_i;
  logic signed [SW-1:0] x_im_i;
  logic                 val_i;
  logic signed [AW-1:0] re_o;
  logic signed [AW-1:0] im_o;
  logic                 val_o;
  logic [15:0]          frm_o;

  modport master (output clr_i, x_re_i, x_im_i, val_i,
                  input  re_o, im_o, val_o, frm_o);
  modport slave  (input  clr_i, x_re_i, x_im_i, val_i,
                  output re_o, im_o, val_o, frm_o);
endinterface

// File: rtl/dft_bin_acc.sv
// dft_bin_acc: single-bin DFT correlator. Each accepted sample is multiplied by
// the Q1.15 twiddle cos(2*pi*k*n/N) - j*sin(2*pi*k*n/N) and accumulated over
// N-sample frames; X[k] is emitted once per frame with a one-cycle val_o.
// Pipeline: S1 sample+twiddle, S2 pair sums, S3 sign-extended contribution,
// then the accumulator/output update.
// Optional feature macro: DFT_BIN_ROUND_EN -- when defined, re_o/im_o carry
// (acc + 2^14) >>> 15 (twiddle Q15 scaling removed, round half up) instead of
// the raw accumulator.
module dft_bin_acc #(
  parameter int N  = 64,
  parameter int SW = 16,
  parameter int K  = 1
) (
  input  logic         clk,
  input  logic         rst,
  dft_bin_acc_if.slave bus
);
  localparam int  AW     = SW + 17 + $clog2(N);
  localparam int  LN     = $clog2(N);
  localparam int  PW     = SW + 17;
  localparam int  STAGES = 3;
  localparam real PI     = 3.14159265358979323846;

  localparam logic [LN-1:0]        K_STEP = LN'(K);
  localparam logic [LN-1:0]        N_LAST = LN'(N - 1);
  localparam logic [LN-1:0]        ONE    = LN'(1);
  localparam logic signed [AW-1:0] HALF   = AW'(16384);

  // Twiddle tables, truncated toward zero, built at elaboration
  logic [N-1:0][15:0] cos_t;
  logic [N-1:0][15:0] sin_t;
  for (genvar gi = 0; gi < N; gi++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(gi) / real'(N);
    assign cos_t[gi] = 16'($rtoi($cos(ANG) * 32767.0));
    assign sin_t[gi] = 16'($rtoi($sin(ANG) * 32767.0));
  end

  logic                 accept;
  logic [LN-1:0]        n_q, n_d, idx_q, idx_d;
  logic [STAGES:1]      vld_pipe_q, vld_pipe_d;
  logic signed [SW-1:0] a1_q, a1_d, b1_q, b1_d;
  logic signed [15:0]   c1_q, c1_d, s1_q, s1_d;
  logic                 last1_q, last1_d, last2_q, last2_d, last3_q, last3_d;
  logic signed [PW-1:0] re2_q, re2_d, im2_q, im2_d;
  logic signed [PW-1:0] ae, be, ce, se;
  logic signed [AW-1:0] re3_q, re3_d, im3_q, im3_d;
  logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [AW-1:0] sum_re, sum_im;
  logic signed [AW-1:0] re_q, re_d, im_q, im_d;
  logic                 val_q, val_d;
  logic [15:0]          frm_q, frm_d;

  // A sample arriving together with clr_i is dropped
  assign accept = bus.val_i & ~bus.clr_i;

  // Output scaling applied when a frame result is loaded
  function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] v);
`ifdef DFT_BIN_ROUND_EN
    return (v + HALF) >>> 15;
`else
    return v;
`endif
  endfunction

  // Sample counter and incremental twiddle index (K*n mod N)
  always_comb begin
    n_d   = n_q;
    idx_d = idx_q;
    if (bus.clr_i) begin
      n_d   = '0;
      idx_d = '0;
    end else if (bus.val_i) begin
      if (n_q == N_LAST) begin
        n_d   = '0;
        idx_d = '0;
      end else begin
        n_d   = n_q + ONE;
        idx_d = idx_q + K_STEP;
      end
    end
  end

  // Datapath stages; data regs load freely, only the valid bits mark content
  always_comb begin
    vld_pipe_d = bus.clr_i ? '0 : {vld_pipe_q[STAGES-1:1], accept};
    a1_d    = bus.x_re_i;
    b1_d    = bus.x_im_i;
    c1_d    = $signed(cos_t[idx_q]);
    s1_d    = $signed(sin_t[idx_q]);
    last1_d = (n_q == N_LAST);
    ae      = PW'(a1_q);
    be      = PW'(b1_q);
    ce      = PW'(c1_q);
    se      = PW'(s1_q);
    re2_d   = ae * ce + be * se;
    im2_d   = be * ce - ae * se;
    last2_d = last1_q;
    re3_d   = AW'(re2_q);
    im3_d   = AW'(im2_q);
    last3_d = last2_q;
  end

  // Accumulate; on the last contribution load outputs and restart from zero
  always_comb begin
    sum_re   = acc_re_q + re3_q;
    sum_im   = acc_im_q + im3_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    re_d     = re_q;
    im_d     = im_q;
    val_d    = 1'b0;
    frm_d    = frm_q;
    if (bus.clr_i) begin
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (vld_pipe_q[STAGES]) begin
      if (last3_q) begin
        acc_re_d = '0;
        acc_im_d = '0;
        re_d     = scale(sum_re);
        im_d     = scale(sum_im);
        val_d    = 1'b1;
        frm_d    = frm_q + 16'd1;
      end else begin
        acc_re_d = sum_re;
        acc_im_d = sum_im;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q        <= '0;
      idx_q      <= '0;
      vld_pipe_q <= '0;
      a1_q       <= '0;
      b1_q       <= '0;
      c1_q       <= '0;
      s1_q       <= '0;
      last1_q    <= 1'b0;
      re2_q      <= '0;
      im2_q      <= '0;
      last2_q    <= 1'b0;
      re3_q      <= '0;
      im3_q      <= '0;
      last3_q    <= 1'b0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      re_q       <= '0;
      im_q       <= '0;
      val_q      <= 1'b0;
      frm_q      <= '0;
    end else begin
      n_q        <= n_d;
      idx_q      <= idx_d;
      vld_pipe_q <= vld_pipe_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      c1_q       <= c1_d;
      s1_q       <= s1_d;
      last1_q    <= last1_d;
      re2_q      <= re2_d;
      im2_q      <= im2_d;
      last2_q    <= last2_d;
      re3_q      <= re3_d;
      im3_q      <= im3_d;
      last3_q    <= last3_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      re_q       <= re_d;
      im_q       <= im_d;
      val_q      <= val_d;
      frm_q      <= frm_d;
    end
  end

  assign bus.re_o  = re_q;
  assign bus.im_o  = im_q;
  assign bus.val_o = val_q;
  assign bus.frm_o = frm_q;
endmodule

// File: tb/tb_dft_bin_acc.sv
// tb_dft_bin_acc: two correlators (bin 0 and bin 1) fed the same stream.
// Expected results come from a direct DFT sum over each accepted frame.
module tb_dft_bin_acc;
  localparam int  N  = 64;
  localparam int  SW = 16;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    int     cyc;
    longint re;
    longint im;
    int     frm;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dft_bin_acc_if #(.N(N), .SW(SW)) if0 ();
  dft_bin_acc_if #(.N(N), .SW(SW)) if1 ();

  dft_bin_acc #(.N(N), .SW(SW), .K(0)) u_k0 (.clk(clk), .rst(rst), .bus(if0));
  dft_bin_acc #(.N(N), .SW(SW), .K(1)) u_k1 (.clk(clk), .rst(rst), .bus(if1));

  int     checks = 0;
  int     errors = 0;
  int     tcnt = 0;
  int     frm_exp = 0;
  int     cos_t[N];
  int     sin_t[N];
  int     fre[$];
  int     fim[$];
  res_t   obs0[$], obs1[$], exp0[$], exp1[$];
  longint l0re, l0im, l1re, l1im, dc_re0;

  // Record every cycle val_o is high, tagged with the edge count
  always @(negedge clk) begin
    if (if0.val_o) obs0.push_back('{tcnt, longint'(if0.re_o), longint'(if0.im_o), int'(if0.frm_o)});
    if (if1.val_o) obs1.push_back('{tcnt, longint'(if1.re_o), longint'(if1.im_o), int'(if1.frm_o)});
  end

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Direct DFT of the collected frame for bin k
  function automatic void bin(input int k, output longint re, output longint im);
    re = 0;
    im = 0;
    for (int n = 0; n < N; n++) begin
      int i;
      i = (k * n) % N;
      re += longint'(fre[n]) * cos_t[i] + longint'(fim[n]) * sin_t[i];
      im += longint'(fim[n]) * cos_t[i] - longint'(fre[n]) * sin_t[i];
    end
`ifdef DFT_BIN_ROUND_EN
    re = (re + 16384) >>> 15;
    im = (im + 16384) >>> 15;
`endif
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, update the scoreboard
  task automatic step(input bit v, input int a, input int b, input bit c);
    if0.val_i = v;  if1.val_i = v;
    if0.x_re_i = SW'(a);  if1.x_re_i = SW'(a);
    if0.x_im_i = SW'(b);  if1.x_im_i = SW'(b);
    if0.clr_i = c;  if1.clr_i = c;
    @(posedge clk);
    #1;
    tcnt++;
    if (c) begin
      fre.delete();
      fim.delete();
      // a clear at or before the result's update edge suppresses it
      while (exp0.size() > 0 && exp0[$].cyc >= tcnt) begin
        void'(exp0.pop_back());
        void'(exp1.pop_back());
        frm_exp--;
      end
    end else if (v) begin
      fre.push_back(a);
      fim.push_back(b);
      if (fre.size() == N) begin
        longint r0, i0, r1, i1;
        bin(0, r0, i0);
        bin(1, r1, i1);
        frm_exp++;
        exp0.push_back('{tcnt + 3, r0, i0, frm_exp});
        exp1.push_back('{tcnt + 3, r1, i1, frm_exp});
        fre.delete();
        fim.delete();
      end
    end
  endtask

  task automatic cmp(input string tag, input res_t o[$], input res_t e[$],
                     output longint lre, output longint lim);
    lre = 0;
    lim = 0;
    chk({tag, " pulses"}, o.size(), e.size());
    for (int i = 0; i < o.size() && i < e.size(); i++) begin
      chk({tag, " cycle"}, o[i].cyc, e[i].cyc);
      chk({tag, " re"},    o[i].re,  e[i].re);
      chk({tag, " im"},    o[i].im,  e[i].im);
      chk({tag, " frm"},   o[i].frm, e[i].frm);
      lre = o[i].re;
      lim = o[i].im;
    end
  endtask

  task automatic settle(input string tag);
    repeat (6) step(0, 0, 0, 0);
    cmp({tag, "/k0"}, obs0, exp0, l0re, l0im);
    cmp({tag, "/k1"}, obs1, exp1, l1re, l1im);
    obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic dc_frame();
    for (int i = 0; i < N; i++) step(1, 1000, 0, 0);
  endtask

  initial begin
    int got;
    for (int i = 0; i < N; i++) begin
      cos_t[i] = $rtoi($cos(2.0 * PI * real'(i) / real'(N)) * 32767.0);
      sin_t[i] = $rtoi($sin(2.0 * PI * real'(i) / real'(N)) * 32767.0);
    end
    if0.val_i = 0; if1.val_i = 0; if0.clr_i = 0; if1.clr_i = 0;
    if0.x_re_i = '0; if1.x_re_i = '0; if0.x_im_i = '0; if1.x_im_i = '0;

    // Reset state
    repeat (3) step(0, 0, 0, 0);
    chk("reset k0 re",  longint'(if0.re_o), 0);
    chk("reset k0 im",  longint'(if0.im_o), 0);
    chk("reset k0 val", if0.val_o, 0);
    chk("reset k0 frm", if0.frm_o, 0);
    chk("reset k1 re",  longint'(if1.re_o), 0);
    chk("reset k1 frm", if1.frm_o, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);

    // DC into bin 0 and bin 1
    dc_frame();
    settle("dc");
    dc_re0 = l0re;
`ifndef DFT_BIN_ROUND_EN
    chk("dc k0 re const", l0re, 64'sd2097088000);
`endif
    chk("dc k0 im zero", l0im, 0);
    chk("dc k1 re small", absl(l1re) < 64000, 1);
    chk("dc k1 im small", absl(l1im) < 64000, 1);

    // Matched tone, two back-to-back frames
    for (int i = 0; i < 2 * N; i++) step(1, cos_t[i % N], sin_t[i % N], 0);
    settle("tone");
`ifdef DFT_BIN_ROUND_EN
    chk("tone k1 re tol", absl(l1re - 2097088) <= 128, 1);
`else
    chk("tone k1 re tol", absl(l1re - 64'sd68715282496) <= (64'sd1 << 22), 1);
    chk("tone k1 im tol", absl(l1im) < (64'sd1 << 22), 1);
`endif

    // Gapped DC input
    got = 0;
    while (got < N) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      step(v, 1000, 0, 0);
      if (v) got++;
    end
    settle("gap");
    chk("gap k0 re vs dc", l0re, dc_re0);

    // Random data with random gaps
    got = 0;
    while (got < N) begin
      bit v;
      v = 1'($urandom_range(0, 3) != 0);
      step(v, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 0);
      if (v) got++;
    end
    settle("rand");

    // Abort after 40 samples (sample with clr dropped), then a clean frame
    for (int i = 0; i < 40; i++) step(1, 1000, 0, 0);
    step(1, 1000, 0, 1);
    dc_frame();
    settle("abort");
    chk("abort k0 re vs dc", l0re, dc_re0);

    // Clear on the very edge the last result would load: suppressed
    dc_frame();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    settle("late clr");
    dc_frame();
    settle("after clr");

    // Asynchronous reset between edges, mid-frame
    for (int i = 0; i < 20; i++) step(1, 1000, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    chk("async k0 re",  longint'(if0.re_o), 0);
    chk("async k0 frm", if0.frm_o, 0);
    chk("async k1 im",  longint'(if1.im_o), 0);
    chk("async k1 frm", if1.frm_o, 0);
    fre.delete(); fim.delete();
    exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
    frm_exp = 0;
    step(0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    dc_frame();
    settle("post rst");
    chk("post rst k0 re vs dc", l0re, dc_re0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so the bench cannot hang
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dft_bin_acc.md
# dft_bin_acc

Single-bin DFT correlator. It consumes a complex sample stream, for example the `cos_o`/`sin_o` outputs of the sine/cosine table generator. Each sample is multiplied by the twiddle factor W(N,k·n) = cos(2πkn/N) − j·sin(2πkn/N), taken from an internal Q1.15 table. The products are accumulated over N-sample frames, and X[k] is emitted once per frame. It sits downstream of the tone generator as the analysis end of the same twiddle-table scheme, and is used for tone detection and loopback checks.

## Interface
- `N`, 64: frame length and table depth; power of two, 4..1024.
- `SW`, 16: input sample width, signed Q1.(SW−1).
- `K`, 1: bin index, 0..N−1.
- `AW`, SW+17+$clog2(N): accumulator/output width (localparam, not overridable).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `clr_i`  in  1  synchronous frame abort/restart.
- `x_re_i`  in  SW  signed real part.
- `x_im_i`  in  SW  signed imaginary part.
- `val_i`  in  1  sample valid; sampled every cycle, no backpressure.
- `re_o`  out  AW  signed Re{X[k]}.
- `im_o`  out  AW  signed Im{X[k]}.
- `val_o`  out  1  one-cycle pulse: new result on `re_o`/`im_o`.
- `frm_o`  out  16  completed-frame count, wraps at 2^16.

## Operation
- **Twiddle table:** `cos_t[i]` = $rtoi(cos(2πi/N)·32767) and `sin_t[i]` = $rtoi(sin(2πi/N)·32767), both 16-bit signed, truncated toward zero. Example: `cos_t[0]` = 32767, `sin_t[N/4]` = 32767.
- **Counters:**
  - Sample counter n runs 0..N−1 and advances only on `val_i`.
  - Table index idx = (K·n) mod N, maintained incrementally: idx ← (idx+K) mod N. On wrap of n, idx ← 0.
- **Arithmetic**, with a = `x_re_i`, b = `x_im_i`, c = `cos_t[idx]`, s = `sin_t[idx]`:
  - re += a·c + b·s
  - im += b·c − a·s
  - Products are full precision (SW+16 bits). Pair sums are SW+17 bits, sign-extended to AW. No saturation; AW guarantees no overflow.
- **Pipeline:** three stages, each carrying a valid bit. Gaps in `val_i` are bubbles.
  - S1 registers the sample, c, s, and a last flag (n = N−1).
  - S2 registers the two pair sums.
  - S3 accumulates.
- **Frame end and back-to-back frames:** on a valid S3 with last set:
  - `re_o`/`im_o` ← acc + contribution.
  - `val_o` ← 1.
  - acc ← 0 in the same cycle.
  - `frm_o` increments.
  - Back-to-back frames therefore need no idle cycle.
- **`clr_i`:** clears n, idx, acc, and the S1–S3 valid bits. A partial frame produces no `val_o`.
  - `re_o`, `im_o` and `frm_o` hold their values.
  - A sample presented together with `clr_i` is dropped.
- **Reset mid-frame:** behaves as `clr_i`, and additionally zeros the outputs and `frm_o`.

## Timing
- **Reset values:** `re_o` = 0, `im_o` = 0, `val_o` = 0, `frm_o` = 0. Internally n = 0, idx = 0, acc = 0, all stage valids = 0.
- **Latency:** last sample accepted at edge t → `val_o` high during the cycle after edge t+3, for exactly one cycle.
  - `re_o`/`im_o` update at edge t+3 and hold until the next frame completes.
- **Throughput:** one sample per cycle sustained. Results are at most one per N accepted samples.
- **`clr_i` and in-flight last sample:** `clr_i` asserted while a last sample is in S1/S2 suppresses that result. `clr_i` in the same cycle as the S3 update also suppresses it.
- `val_i` toggling has no effect on timing beyond bubble propagation.

## Configuration
- `DFT_BIN_ROUND_EN`
  - **Defined:** `re_o`/`im_o` = (acc + 2^14) >>> 15, i.e. round-half-up removal of the twiddle Q15 scaling. The result is sign-extended to AW; latency is unchanged (the rounding is folded into the S3 output load).
  - **Undefined:** raw accumulator value, Q(SW−1)+15 scaling.

## Test plan
Defaults unless noted: N = 64, SW = 16, K = 1.

1. **DC, bin 0:** K = 0, x = (1000, 0) for 64 consecutive samples → one `val_o` pulse 3 cycles after the last sample.
   - `re_o` = 2097088000, `im_o` = 0.
   - `frm_o` = 1.
2. **Matched tone:** x = (`cos_t[n]`, `sin_t[n]`) at amplitude 32767, 2 back-to-back frames.
   - Two `val_o` pulses exactly 64 cycles apart.
   - `re_o` within 64·32767² ± 2^22; |`im_o`| < 2^22.
   - With `DFT_BIN_ROUND_EN`: `re_o` = 2097088 ± 128.
3. **DC into bin 1:** x = (1000, 0).
   - |`re_o`| < 64000 and |`im_o`| < 64000 (table truncation residue only).
4. **Gapped input:** the stimulus of case 1 with `val_i` randomly deasserted ~50%.
   - Identical `re_o`/`im_o` to case 1.
   - `val_o` 3 cycles after the 64th accepted sample.
5. **Abort:** 40 samples, then `clr_i` (with `val_i` = 1 that cycle), then 64 samples of the case-1 stimulus.
   - Only one `val_o`, carrying exactly the case-1 values.
6. **Async reset:** `rst` low mid-frame, asynchronously between edges.
   - All outputs read 0 immediately.
   - After release, a full frame reproduces case 1 with `frm_o` = 1.
